// File: rtl/uart_rx_addr_fifo.sv
// Receive-side frame buffer for a 9-bit multidrop UART: address filtering FSM
// feeding a first-word-fall-through FIFO with sticky overrun and drop counter.
module uart_rx_addr_fifo #(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] BCAST_ADDR = 8'hFF,
  parameter int         LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_done,
  input  logic [8:0]       rx_data,
  input  logic             filter_en,
  input  logic [7:0]       my_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_is_addr,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {LISTEN, SELECTED} state_t;

  state_t           state, state_next;
  logic             addr_match;
  logic             accept;
  logic             push, pop, drop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic [8:0]       mem [DEPTH];

  assign addr_match = (rx_data[7:0] == my_addr) || (rx_data[7:0] == BCAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks use blocking with a default first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= LISTEN;
    else         state <= state_next;
  end

  // Address frames steer the FSM even when the FIFO is full.
  always_comb begin
    state_next = state;
    if (rx_done && filter_en && rx_data[8])
      state_next = addr_match ? SELECTED : LISTEN;
  end

  always_comb begin
    accept = 1'b0;
    if (rx_done) begin
      if (!filter_en)     accept = 1'b1;
      else if (rx_data[8]) accept = addr_match;
      else                accept = (state == SELECTED);
    end
  end

  // A pop frees the slot, so a full FIFO still accepts on a simultaneous read.
  assign pop  = out_valid && out_ready;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  // NOTE: storage has no reset; validity is carried entirely by the pointers
  // and level, and the read port is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level     <= level_next;
      out_valid <= (level_next != '0);
      full      <= (level_next == LVL_W'(DEPTH));
    end
  end

  assign out_data    = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_is_addr = out_valid ? mem[rd_ptr][8]   : 1'b0;

  // A drop in the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun  <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overrun  <= 1'b1;
      if (overrun_clr)            drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (overrun_clr) begin
      overrun  <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_addr_fifo.sv
// Directed self-checking bench for uart_rx_addr_fifo (DEPTH=16).
module tb_uart_rx_addr_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             rx_done = 1'b0;
  logic [8:0]       rx_data = '0;
  logic             filter_en = 1'b0;
  logic [7:0]       my_addr = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             out_is_addr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             overrun;
  logic             overrun_clr = 1'b0;
  logic [7:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_addr_fifo #(.DEPTH(DEPTH), .BCAST_ADDR(8'hFF)) dut (
    .clk(clk), .resetn(resetn), .rx_done(rx_done), .rx_data(rx_data),
    .filter_en(filter_en), .my_addr(my_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_is_addr(out_is_addr),
    .level(level), .full(full), .overrun(overrun), .overrun_clr(overrun_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({out_valid, out_data, out_is_addr, level, full, overrun, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h a=%b lvl=%0d f=%b o=%b dc=%0d exp all 0",
               out_valid, out_data, out_is_addr, level, full, overrun, drop_cnt);
    end
    #20 resetn = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    logic [8:0] frames [3];
    frames = '{9'h041, 9'h142, 9'h043};
    filter_en = 1'b0;
    send(frames[0]);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL t1_latency out_valid got %b exp 1", out_valid);
    end
    send(frames[1]);
    send(frames[2]);
    n_tests++;
    if (level !== LVL_W'(3)) begin
      n_fail++; $display("FAIL t1_level got %0d exp 3", level);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({out_valid, out_is_addr, out_data} !== {1'b1, frames[i]}) begin
        n_fail++;
        $display("FAIL t1_head%0d got v=%b a=%b d=%h exp v=1 a=%b d=%h",
                 i, out_valid, out_is_addr, out_data, frames[i][8], frames[i][7:0]);
      end
      pop();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_empty out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_filter();
    logic [8:0] stim [6];
    logic [8:0] exp_q [2];
    stim  = '{9'h107, 9'h0AA, 9'h105, 9'h0BB, 9'h106, 9'h0CC};
    exp_q = '{9'h105, 9'h0BB};
    filter_en = 1'b1;
    my_addr   = 8'h05;
    for (int i = 0; i < 6; i++) send(stim[i]);
    n_tests++;
    if (level !== LVL_W'(2) || overrun !== 1'b0) begin
      n_fail++; $display("FAIL t2_level got %0d ovr=%b exp 2 ovr=0", level, overrun);
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({out_valid, out_is_addr, out_data} !== {1'b1, exp_q[i]}) begin
        n_fail++;
        $display("FAIL t2_head%0d got v=%b a=%b d=%h exp a=%b d=%h",
                 i, out_valid, out_is_addr, out_data, exp_q[i][8], exp_q[i][7:0]);
      end
      pop();
    end
  endtask

  task automatic test_broadcast();
    logic [8:0] stim [2];
    stim = '{9'h1FF, 9'h011};
    filter_en = 1'b1;
    for (int i = 0; i < 2; i++) send(stim[i]);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({out_valid, out_is_addr, out_data} !== {1'b1, stim[i]}) begin
        n_fail++;
        $display("FAIL t3_head%0d got v=%b a=%b d=%h exp a=%b d=%h",
                 i, out_valid, out_is_addr, out_data, stim[i][8], stim[i][7:0]);
      end
      pop();
    end
  endtask

  task automatic test_overrun();
    filter_en = 1'b0;
    for (int i = 0; i < 16; i++) send(9'(i));
    n_tests++;
    if (full !== 1'b1 || level !== LVL_W'(16) || overrun !== 1'b0) begin
      n_fail++; $display("FAIL t4_full got f=%b lvl=%0d ovr=%b exp f=1 lvl=16 ovr=0", full, level, overrun);
    end
    send(9'h010);
    send(9'h011);
    n_tests++;
    if (overrun !== 1'b1 || drop_cnt !== 8'd2 || level !== LVL_W'(16)) begin
      n_fail++; $display("FAIL t4_drop got ovr=%b dc=%0d lvl=%0d exp ovr=1 dc=2 lvl=16", overrun, drop_cnt, level);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || out_is_addr !== 1'b0) begin
        n_fail++; $display("FAIL t4_drain%0d got v=%b d=%h a=%b exp v=1 d=%h a=0", i, out_valid, out_data, out_is_addr, 8'(i));
      end
      pop();
    end
    n_tests++;
    if (out_valid !== 1'b0 || full !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL t4_empty got v=%b f=%b ovr=%b exp v=0 f=0 ovr=1", out_valid, full, overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL t4_clr got ovr=%b dc=%0d exp 0 0", overrun, drop_cnt);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++) send(9'h020 + 9'(i));
    rx_data   = 9'h077;
    rx_done   = 1'b1;
    out_ready = 1'b1;
    tick();
    rx_done   = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (level !== LVL_W'(16) || full !== 1'b1 || overrun !== 1'b0 || out_data !== 8'h21) begin
      n_fail++;
      $display("FAIL t5_pushpop got lvl=%0d f=%b ovr=%b head=%h exp lvl=16 f=1 ovr=0 head=21",
               level, full, overrun, out_data);
    end
  endtask

  // Runs on the full FIFO left by test_full_pushpop, then drains it.
  task automatic test_drop_sat_and_clr();
    send(9'h0E0);
    n_tests++;
    if (overrun !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL t7_first_drop got ovr=%b dc=%0d exp 1 1", overrun, drop_cnt);
    end
    for (int i = 0; i < 255; i++) send(9'h0E1);
    n_tests++;
    if (drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL t7_saturate got dc=%0d exp 255", drop_cnt);
    end
    rx_data     = 9'h0E2;
    rx_done     = 1'b1;
    overrun_clr = 1'b1;
    tick();
    rx_done     = 1'b0;
    overrun_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL t7_set_wins got ovr=%b dc=%0d exp 1 1", overrun, drop_cnt);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL t7_clr got ovr=%b dc=%0d exp 0 0", overrun, drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'h21 + 8'(i) : 8'h77;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        n_fail++; $display("FAIL t5_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d);
      end
      pop();
    end
    n_tests++;
    if (level !== LVL_W'(0) || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t5_empty got lvl=%0d v=%b exp 0 0", level, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    filter_en = 1'b1;
    my_addr   = 8'h05;
    send(9'h105);
    for (int i = 0; i < 4; i++) send(9'h050 + 9'(i));
    n_tests++;
    if (level !== LVL_W'(5)) begin
      n_fail++; $display("FAIL t6_pre_level got %0d exp 5", level);
    end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_is_addr, level, full, overrun, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL t6_async_reset got v=%b d=%h a=%b lvl=%0d f=%b o=%b dc=%0d exp all 0",
               out_valid, out_data, out_is_addr, level, full, overrun, drop_cnt);
    end
    #3 resetn = 1'b1;
    tick();
    send(9'h0AA);
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || level !== LVL_W'(0)) begin
      n_fail++; $display("FAIL t6_listen_discard got v=%b lvl=%0d exp 0 0", out_valid, level);
    end
    send(9'h105);
    send(9'h0AB);
    n_tests++;
    if (level !== LVL_W'(2) || out_data !== 8'h05 || out_is_addr !== 1'b1) begin
      n_fail++; $display("FAIL t6_reselect got lvl=%0d d=%h a=%b exp 2 05 1", level, out_data, out_is_addr);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_filter();
    test_broadcast();
    test_overrun();
    test_full_pushpop();
    test_drop_sat_and_clr();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
